// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one start/done ALU among NUM_REQ requesters.
// Round-robin grant, operand latch, one-cycle start pulse, then the result
// comes back on a valid/ready response channel tagged with the requester id.
// Optional build macro ALU_SHARE_ARBITER_TIMEOUT_EN adds a WAIT watchdog that
// answers 16'hDEAD with rsp_err_o=1 after TIMEOUT_CYCLES without done.
module alu_share_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic [3*NUM_REQ-1:0] req_op_i,
  input  logic [8*NUM_REQ-1:0] req_a_i,
  input  logic [8*NUM_REQ-1:0] req_b_i,
  output logic [2:0]           alu_op_o,
  output logic [7:0]           alu_a_o,
  output logic [7:0]           alu_b_o,
  output logic                 alu_start_o,
  input  logic                 alu_done_i,
  input  logic [15:0]          alu_res_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [ID_W-1:0]      rsp_id_o,
  output logic [15:0]          rsp_data_o,
  output logic                 rsp_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_cfg_err
    $error("alu_share_arbiter: unsupported parameter set");
  end

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_last_q, rr_last_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [2:0]      op_q, op_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;
  logic [15:0]     data_q, data_d;
  // One IDLE cycle after each response is kept grant-free so requesters can
  // react to the response before the next arbitration round.
  logic            hold_q, hold_d;

  logic            gnt_vld;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] cand;
  logic            grant;

  logic [2:0] op_arr [NUM_REQ];
  logic [7:0] a_arr  [NUM_REQ];
  logic [7:0] b_arr  [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign op_arr[k] = req_op_i[3*k +: 3];
    assign a_arr[k]  = req_a_i[8*k +: 8];
    assign b_arr[k]  = req_b_i[8*k +: 8];
  end

`ifdef ALU_SHARE_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Round-robin search: first valid requester after the last winner, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_last_q) + i) % NUM_REQ);
      if (!gnt_vld && req_valid_i[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // A grant is only offered from an open IDLE cycle and never while in reset.
  assign grant = (state_q == S_IDLE) && !hold_q && reset_i && gnt_vld;

  // One-hot accept pulse for the winner.
  always_comb begin
    req_ready_o = '0;
    if (grant) req_ready_o[gnt_idx] = 1'b1;
  end

  // Next-state and register updates for the arbitration/transaction FSM.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    id_d      = id_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    hold_d    = 1'b0;
`ifdef ALU_SHARE_ARBITER_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          op_d      = op_arr[gnt_idx];
          a_d       = a_arr[gnt_idx];
          b_d       = b_arr[gnt_idx];
          id_d      = gnt_idx;
          rr_last_d = gnt_idx;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // done is not looked at here; the ALU has only just been started
        state_d = S_WAIT;
`ifdef ALU_SHARE_ARBITER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (alu_done_i) begin
          data_d  = alu_res_i;
          state_d = S_RESP;
`ifdef ALU_SHARE_ARBITER_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          data_d  = 16'hDEAD;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
          hold_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      rr_last_q <= ID_W'(NUM_REQ - 1);
      id_q      <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      data_q    <= '0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      id_q      <= id_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      data_q    <= data_d;
      hold_q    <= hold_d;
    end
  end

`ifdef ALU_SHARE_ARBITER_TIMEOUT_EN
  // Watchdog counter and error flag.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign rsp_err_o = err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  assign alu_op_o    = op_q;
  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign alu_start_o = (state_q == S_ISSUE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_id_o    = id_q;
  assign rsp_data_o  = data_q;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one ALU datapath among NUM_REQ requesters. The ALU has 8-bit A/B, a 3-bit op, a start/done handshake and a 16-bit result.
- Arbitrates round-robin and latches the winner's operands.
- Pulses ALU start, waits for done, then returns the result tagged with the requester id.
- Sits between traffic generators and the ALU BFM in the simulation top.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of requester id
TIMEOUT_CYCLES, 64, max cycles waiting for done (used only with the optional feature)

Ports:
clk_i  in  1  clock, all logic on rising edge
reset_i  in  1  synchronous active-low reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  one-hot accept pulse
req_op_i  in  3*NUM_REQ  packed op, requester k at [3k+2:3k]
req_a_i  in  8*NUM_REQ  packed A operand
req_b_i  in  8*NUM_REQ  packed B operand
alu_op_o  out  3  op to ALU
alu_a_o  out  8  A to ALU
alu_b_o  out  8  B to ALU
alu_start_o  out  1  one-cycle start pulse
alu_done_i  in  1  ALU completion
alu_res_i  in  16  ALU result, valid when alu_done_i=1
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accept
rsp_id_o  out  ID_W  id of requester that owns the response
rsp_data_o  out  16  result
rsp_err_o  out  1  timeout flag (tied 0 without the optional feature)

Behaviour:
- Reset (reset_i=0 at a rising edge): state=IDLE. All outputs 0. Operand registers 0. rr_last=NUM_REQ-1, so requester 0 has first priority. Reset wins over every other event in any state, including mid-WAIT; an in-flight transaction is dropped with no response.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid_i bit is set, grant g = first valid index searching (rr_last+1) mod NUM_REQ upward with wrap.
  - In the same cycle, req_ready_o[g]=1 combinationally and only that bit.
  - At the edge: latch op/A/B of g, record id=g, set rr_last=g, go to ISSUE.
  - If no request is valid, stay in IDLE with req_ready_o=0.
- ISSUE: alu_start_o=1 for exactly this cycle, operands driven from the latches; go to WAIT. alu_done_i is ignored in ISSUE.
- WAIT:
  - alu_op_o/alu_a_o/alu_b_o stay stable.
  - On alu_done_i=1: latch alu_res_i into rsp_data_o, set rsp_err_o=0, go to RESP.
- RESP:
  - rsp_valid_o=1; rsp_id_o and rsp_data_o are held stable until rsp_ready_i=1.
  - On the handshake edge: rsp_valid_o goes 0, state goes to IDLE.
  - No grant is made in the RESP cycle.
- Minimum latency: accept at cycle 0, start at cycle 1, done earliest at cycle 2, rsp_valid at cycle 3. With rsp_ready_i=1, the next accept is at cycle 5.
- alu_done_i in IDLE or RESP is a stray pulse: ignore it, with no state or output change.
- req_ready_o is never asserted outside IDLE. A requester keeps valid high until it sees ready.
- A request that drops valid before grant is not latched.
- Result width is 16 bits, passed through unmodified. No arithmetic is done in this block.

Optional Feature:
Macro: ALU_SHARE_ARBITER_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without done: go to RESP with rsp_data_o=16'hDEAD and rsp_err_o=1.
  - A done arriving after the timeout is a stray pulse and is ignored.
- Not defined: no counter is built, rsp_err_o is constant 0, and WAIT waits indefinitely.

Test Plan:
- Single request: req0 op=3'd0, A=8'h12, B=8'h34, ALU model adds and asserts done 1 cycle after start -> ready[0] at c0, start at c1 with 0/12/34, rsp at c3 with id=0, data=16'h0046.
- All four requesters valid continuously -> grant order 0,1,2,3,0. Each ready is one-hot and each response id matches its grant.
- Backpressure: hold rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid, id and data stable, no req_ready_o, no start. Release -> IDLE, next grant 2 cycles later.
- Reset mid-WAIT: assert reset_i=0 for 1 cycle before done -> next cycle all outputs 0, state IDLE. The following done is ignored and the first grant after reset is req0.
- Stray done: pulse alu_done_i in IDLE with no requests -> no rsp_valid_o, no state change.
- With ALU_SHARE_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=8, ALU never done -> rsp_valid at WAIT+8 with data=16'hDEAD, err=1. A late done is ignored.
